// File: rtl/complete_arbiter.sv
// complete_arbiter: per-pipe completion FIFOs round-robin arbitrated onto one complete bus
module complete_arbiter #(
  parameter int p_num_pipes = 4,
  parameter int p_seq_num_bits = 5,
  parameter int p_num_phys_regs = 36,
  parameter int p_buf_depth = 2,
  localparam int p_phys_addr_bits = $clog2(p_num_phys_regs)
) (
  input  logic clk,
  input  logic rst,
  input  logic [p_num_pipes-1:0] pipe_val,
  output logic [p_num_pipes-1:0] pipe_rdy,
  input  logic [p_num_pipes-1:0][p_seq_num_bits-1:0] pipe_seq_num,
  input  logic [p_num_pipes-1:0][4:0] pipe_waddr,
  input  logic [p_num_pipes-1:0][p_phys_addr_bits-1:0] pipe_preg,
  input  logic [p_num_pipes-1:0] pipe_wen,
  input  logic [p_num_pipes-1:0][31:0] pipe_wdata,
  output logic complete_val,
  output logic [p_seq_num_bits-1:0] complete_seq_num,
  output logic [4:0] complete_waddr,
  output logic [p_phys_addr_bits-1:0] complete_preg,
  output logic complete_wen,
  output logic [31:0] complete_wdata,
  output logic [p_num_pipes-1:0] grant_oh
);
  localparam int iw = $clog2(p_buf_depth);
  localparam int cw = iw + 1;
  localparam int nw = $clog2(p_num_pipes);
  typedef struct packed {
    logic [p_seq_num_bits-1:0] seq;
    logic [4:0] waddr;
    logic [p_phys_addr_bits-1:0] preg;
    logic wen;
    logic [31:0] wdata;
  } entry_t;
  entry_t mem [p_num_pipes][p_buf_depth];
  entry_t head_e;
  logic [p_num_pipes-1:0][cw-1:0] count;
  logic [p_num_pipes-1:0][iw-1:0] head, tail;
  logic [nw-1:0] ptr, gidx;
  logic [nw-1:0] cand [p_num_pipes];
  logic [p_num_pipes-1:0] req, enq;
  logic any;
  always_comb begin
    for (int k = 0; k < p_num_pipes; k++) begin
      req[k] = count[k] != '0;
      pipe_rdy[k] = rst & (count[k] < cw'(p_buf_depth));
    end
  end
  assign enq = pipe_val & pipe_rdy;
  assign any = |req;
  // cand[i] is the pipe visited i-th in the round-robin scan starting at ptr
  for (genvar i = 0; i < p_num_pipes; i++) begin : g_cand
    assign cand[i] = nw'((int'(ptr) + i) % p_num_pipes);
  end
  always_comb begin
    gidx = '0;
    for (int i = p_num_pipes - 1; i >= 0; i--)
      if (req[cand[i]]) gidx = cand[i];
  end
  assign grant_oh = any ? (p_num_pipes'(1) << gidx) : '0;
  assign head_e = mem[gidx][head[gidx]];
  assign complete_val = any;
  assign {complete_seq_num, complete_waddr, complete_preg, complete_wen, complete_wdata} = any ? head_e : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      count <= '0;
      head <= '0;
      tail <= '0;
      ptr <= '0;
    end else begin
      for (int k = 0; k < p_num_pipes; k++) begin
        if (enq[k]) tail[k] <= tail[k] + iw'(1);
        if (grant_oh[k]) head[k] <= head[k] + iw'(1);
        count[k] <= count[k] + cw'(enq[k]) - cw'(grant_oh[k]);
      end
      if (any) ptr <= (int'(gidx) == p_num_pipes - 1) ? '0 : gidx + nw'(1);
    end
  always_ff @(posedge clk)
    for (int k = 0; k < p_num_pipes; k++)
      if (enq[k]) mem[k][tail[k]] <= {pipe_seq_num[k], pipe_waddr[k], pipe_preg[k], pipe_wen[k], pipe_wdata[k]};
endmodule

// File: tb/tb_complete_arbiter.sv
// tb_complete_arbiter: randomized and directed checks of complete_arbiter against a queue model
module tb_complete_arbiter;
  localparam int n = 4;
  localparam int depth = 2;
  logic clk = 0;
  logic rst = 0;
  logic [n-1:0] pipe_val = '0;
  logic [n-1:0] pipe_rdy;
  logic [n-1:0][4:0] pipe_seq_num = '0;
  logic [n-1:0][4:0] pipe_waddr = '0;
  logic [n-1:0][5:0] pipe_preg = '0;
  logic [n-1:0] pipe_wen = '0;
  logic [n-1:0][31:0] pipe_wdata = '0;
  logic complete_val;
  logic [4:0] complete_seq_num;
  logic [4:0] complete_waddr;
  logic [5:0] complete_preg;
  logic complete_wen;
  logic [31:0] complete_wdata;
  logic [n-1:0] grant_oh;
  int total = 0;
  int bad = 0;
  logic [48:0] q [n][$];
  int mptr = 0;

  complete_arbiter dut (
    .clk(clk), .rst(rst), .pipe_val(pipe_val), .pipe_rdy(pipe_rdy),
    .pipe_seq_num(pipe_seq_num), .pipe_waddr(pipe_waddr), .pipe_preg(pipe_preg),
    .pipe_wen(pipe_wen), .pipe_wdata(pipe_wdata), .complete_val(complete_val),
    .complete_seq_num(complete_seq_num), .complete_waddr(complete_waddr),
    .complete_preg(complete_preg), .complete_wen(complete_wen),
    .complete_wdata(complete_wdata), .grant_oh(grant_oh)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // At a negedge: compare DUT against the model, then drive v and advance the model past the next posedge
  task automatic tick(input logic [n-1:0] v, input bit rnd);
    int g;
    logic [n-1:0] rdy;
    @(negedge clk);
    g = -1;
    for (int i = 0; i < n; i++)
      if (g < 0 && q[(mptr + i) % n].size() != 0) g = (mptr + i) % n;
    for (int k = 0; k < n; k++) rdy[k] = q[k].size() < depth;
    chk("rdy", 64'(pipe_rdy), 64'(rdy));
    chk("val", 64'(complete_val), 64'(g >= 0));
    chk("grant", 64'(grant_oh), g >= 0 ? 64'(1) << g : 64'(0));
    chk("data", 64'({complete_seq_num, complete_waddr, complete_preg, complete_wen, complete_wdata}),
        g >= 0 ? 64'(q[g][0]) : 64'(0));
    pipe_val = v;
    for (int k = 0; k < n; k++) begin
      if (rnd) begin
        pipe_seq_num[k] = 5'($urandom);
        pipe_waddr[k] = 5'($urandom);
        pipe_preg[k] = 6'($urandom_range(35));
        pipe_wen[k] = 1'($urandom);
        pipe_wdata[k] = $urandom;
      end
      if (v[k] && rdy[k])
        q[k].push_back({pipe_seq_num[k], pipe_waddr[k], pipe_preg[k], pipe_wen[k], pipe_wdata[k]});
    end
    if (g >= 0) begin
      void'(q[g].pop_front());
      mptr = (g + 1) % n;
    end
  endtask

  initial begin
    int buffered;
    pipe_val = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_rdy", 64'(pipe_rdy), 64'(0));
      chk("rst_val", 64'(complete_val), 64'(0));
      chk("rst_grant", 64'(grant_oh), 64'(0));
    end
    rst = 1;
    pipe_val = '0;
    #1 chk("rel_rdy", 64'(pipe_rdy), 64'(4'b1111));
    pipe_seq_num[2] = 5'd3;
    pipe_preg[2] = 6'd17;
    pipe_wdata[2] = 32'hDEADBEEF;
    pipe_wen[2] = 1'b1;
    pipe_waddr[2] = 5'd9;
    tick(4'b0100, 0);
    @(posedge clk);
    #1;
    chk("single_val", 64'(complete_val), 64'(1));
    chk("single_seq", 64'(complete_seq_num), 64'(3));
    chk("single_preg", 64'(complete_preg), 64'(17));
    chk("single_wdata", 64'(complete_wdata), 64'hDEADBEEF);
    chk("single_grant", 64'(grant_oh), 64'(4'b0100));
    tick(4'b0000, 0);
    tick(4'b0000, 0);
    for (int k = 0; k < n; k++) pipe_seq_num[k] = 5'(k);
    tick(4'b1111, 0);
    for (int c = 0; c < 5; c++) tick(4'b0000, 1);
    tick(4'b0100, 1);
    tick(4'b1001, 1);
    tick(4'b1001, 1);
    for (int c = 0; c < 6; c++) tick(4'b0000, 1);
    for (int c = 0; c < 12; c++) tick(4'b0011, 1);
    for (int c = 0; c < 4; c++) tick(4'b0000, 1);
    for (int c = 0; c < 2000; c++) tick(4'($urandom), 1);
    for (int c = 0; c < 20; c++) begin
      buffered = 0;
      for (int k = 0; k < n; k++) buffered += q[k].size();
      if (buffered >= 5) break;
      tick(4'b1111, 1);
    end
    chk("pre_reset_fill", 64'(buffered >= 5), 64'(1));
    @(posedge clk);
    #2 rst = 0;
    #1;
    chk("mid_rst_val", 64'(complete_val), 64'(0));
    chk("mid_rst_grant", 64'(grant_oh), 64'(0));
    chk("mid_rst_rdy", 64'(pipe_rdy), 64'(0));
    for (int k = 0; k < n; k++) q[k].delete();
    mptr = 0;
    pipe_val = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    for (int c = 0; c < 10; c++) tick(4'b0000, 1);
    for (int c = 0; c < 500; c++) tick(4'($urandom), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
